// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder (OV7670 register-port model).
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDevId,
    StAckId,
    StSubAddr,
    StAckSub,
    StWrData,
    StAckData,
    StRdData,
    StRdNa,
    StWaitStop
  } sccb_state_e;

  localparam logic [6:0]  DefDevAddr = 7'h21;
  localparam int unsigned PhaseBits  = 9;
  localparam int unsigned BankDepth  = 256;

  localparam logic [7:0] PidAddr  = 8'h0A;
  localparam logic [7:0] PidVal   = 8'h76;
  localparam logic [7:0] VerAddr  = 8'h0B;
  localparam logic [7:0] VerVal   = 8'h73;
  localparam logic [7:0] Com7Addr = 8'h12;
  localparam logic [7:0] Com7Val  = 8'h00;

  function automatic logic [7:0] bank_reset_val(input logic [7:0] addr);
    case (addr)
      PidAddr:  return PidVal;
      VerAddr:  return VerVal;
      Com7Addr: return Com7Val;
      default:  return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA into clk_in and decodes SCL edges plus START/STOP conditions.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sccb_scl,
  input  logic sccb_sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], sccb_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sccb_sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // Requiring SCL stable high suppresses START/STOP when both lines move together.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave modelling the OV7670 register port: 256x8 bank, 3-phase write, 2+2-phase read.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = DefDevAddr,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sccb_scl,
  input  logic       sccb_sda_in,
  output logic       sccb_sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] LastBit  = 4'(PhaseBits - 2);
  localparam logic [3:0] ByteBits = 4'(PhaseBits - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .sccb_scl   (sccb_scl),
    .sccb_sda_in(sccb_sda_in),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .sda_s      (sda_s)
  );

  sccb_state_e state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  sub_addr_q, sub_addr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  bank_q [BankDepth];
  logic        bank_we;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [2:0]  rd_idx;

  assign rx_byte = {shift_q, sda_s};
  assign rd_byte = bank_q[sub_addr_q];
  assign rd_idx  = 3'(4'd7 - bit_cnt_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sub_addr_d  = sub_addr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_we     = 1'b0;

    if (stop_det) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = StDevId;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StDevId, StSubAddr, StWrData: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
              if (state_q == StDevId) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == DEV_ADDR) ? StAckId : StWaitStop;
              end else if (state_q == StSubAddr) begin
                sub_addr_d = rx_byte;
                state_d    = StAckSub;
              end else begin
                bank_we     = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = sub_addr_q;
                wr_data_d   = rx_byte;
                state_d     = StAckData;
              end
            end
          end
        end
        // First SCL fall starts the ACK low, the second one ends the 9th bit.
        StAckId, StAckSub, StAckData: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == StAckId) begin
                if (rw_q) begin
                  state_d  = StRdData;
                  sda_oe_d = ~rd_byte[7];
                end else begin
                  state_d = StSubAddr;
                end
              end else if (state_q == StAckSub) begin
                state_d = StWrData;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == ByteBits) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRdNa;
            end else begin
              sda_oe_d = ~rd_byte[rd_idx];
            end
          end
        end
        StRdNa: begin
          if (scl_rise) state_d = StWaitStop;
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sub_addr_q  <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sub_addr_q  <= sub_addr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BankDepth; i++) begin
        bank_q[i] <= bank_reset_val(8'(i));
      end
    end else if (bank_we) begin
      bank_q[sub_addr_q] <= rx_byte;
    end
  end

  assign sccb_sda_oe = sda_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench: bit-banged SCCB initiator with open-drain SDA against sccb_responder.
module tb_sccb_responder;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       sccb_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sccb_sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_line = m_sda & ~sccb_sda_oe;

  always #5 clk_in = ~clk_in;

  sccb_responder u_dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sccb_scl   (sccb_scl),
    .sccb_sda_in(sda_line),
    .sccb_sda_oe(sccb_sda_oe),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // Cumulative monitor, sampled on the falling clock edge.
  int unsigned cyc, strobe_cnt, oe_rise_cnt, strobe_run, strobe_max;
  int unsigned last_rise_cyc, last_fall_cyc, strobe_lat, oe_lat;
  logic        scl_prev = 1'b1;
  logic        oe_prev = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (sccb_scl && !scl_prev) last_rise_cyc = cyc;
    if (!sccb_scl && scl_prev) last_fall_cyc = cyc;
    scl_prev = sccb_scl;
    if (wr_strobe) begin
      if (strobe_run == 0) begin
        strobe_cnt++;
        strobe_lat = cyc - last_rise_cyc;
      end
      strobe_run++;
      if (strobe_run > strobe_max) strobe_max = strobe_run;
    end else begin
      strobe_run = 0;
    end
    if (sccb_sda_oe && !oe_prev) begin
      oe_rise_cnt++;
      oe_lat = cyc - last_fall_cyc;
    end
    oe_prev = sccb_sda_oe;
  end

  int unsigned n_vec, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Quarter SCL period = 4 clk_in; pins move 1ns after a rising clock edge.
  task automatic wait_q();
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b0; wait_q();
    sccb_scl = 1'b0; wait_q();
  endtask

  task automatic bus_rep_start();
    m_sda = 1'b1; wait_q();
    sccb_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    sccb_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    sccb_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q();
    sccb_scl = 1'b1; wait_q(); wait_q();
    sccb_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    sccb_scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    sccb_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] data, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] data);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      data[i] = b;
    end
    send_bit(1'b1);
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    logic a;
    bus_start();
    write_byte(8'h42, a);
    write_byte(addr, a);
    bus_rep_start();
    write_byte(8'h43, a);
    read_byte(data);
    bus_stop();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a0, a1, a2;
    logic [7:0] rd;
    int unsigned s0, o0;

    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_sda_oe", sccb_sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_wr_data", wr_data, 8'h00);
    rst = 1'b1;
    wait_q();

    // Three-phase write 0x80 -> reg 0x12.
    s0 = strobe_cnt; o0 = oe_rise_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h12, a1);
    write_byte(8'h80, a2);
    check_eq("t1_busy_mid", busy, 1);
    check_eq("t1_ack_lat", oe_lat, 3);
    bus_stop();
    check_eq("t1_ack_id", a0, 1);
    check_eq("t1_ack_sub", a1, 1);
    check_eq("t1_ack_data", a2, 1);
    check_eq("t1_oe_pulses", oe_rise_cnt - o0, 3);
    check_eq("t1_strobes", strobe_cnt - s0, 1);
    check_eq("t1_strobe_lat", strobe_lat, 3);
    check_eq("t1_wr_addr", wr_addr, 8'h12);
    check_eq("t1_wr_data", wr_data, 8'h80);
    check_eq("t1_busy_after", busy, 0);

    // Two-phase write of 0x0A, STOP, then two-phase read of PID.
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    bus_stop();
    bus_start();
    write_byte(8'h43, a2);
    read_byte(rd);
    bus_stop();
    check_eq("t2_ack_rd_id", a2, 1);
    check_eq("t2_pid", rd, 8'h76);
    check_eq("t2_strobes", strobe_cnt - s0, 0);

    // Foreign device ID: never acknowledged, nothing written.
    s0 = strobe_cnt; o0 = oe_rise_cnt;
    bus_start();
    write_byte(8'h60, a0);
    write_byte(8'h12, a1);
    write_byte(8'h55, a2);
    bus_stop();
    check_eq("t3_nack_id", a0, 0);
    check_eq("t3_nack_data", a2, 0);
    check_eq("t3_oe_pulses", oe_rise_cnt - o0, 0);
    check_eq("t3_strobes", strobe_cnt - s0, 0);
    read_reg(8'h12, rd);
    check_eq("t3_reg12_kept", rd, 8'h80);

    // Repeated-start read of an unwritten register.
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h3A, a1);
    bus_rep_start();
    write_byte(8'h43, a2);
    read_byte(rd);
    bus_stop();
    check_eq("t4_ack_id", a0, 1);
    check_eq("t4_ack_rd_id", a2, 1);
    check_eq("t4_reg3a", rd, 8'h00);

    // STOP after a partial data byte commits nothing.
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h12, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    check_eq("t5_strobes", strobe_cnt - s0, 0);
    read_reg(8'h12, rd);
    check_eq("t5_reg12_kept", rd, 8'h80);

    // Reset while the responder is pulling SDA for a read bit (PID bit 7 = 0).
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    bus_rep_start();
    write_byte(8'h43, a2);
    check_eq("t6_oe_before", sccb_sda_oe, 1);
    rst = 1'b0;
    #1;
    check_eq("t6_oe_rst", sccb_sda_oe, 0);
    check_eq("t6_busy_rst", busy, 0);
    wait_q();
    rst = 1'b1;
    sccb_scl = 1'b1;
    m_sda = 1'b1;
    wait_q(); wait_q();
    read_reg(8'h0A, rd);
    check_eq("t6_pid", rd, 8'h76);
    read_reg(8'h12, rd);
    check_eq("t6_reg12_default", rd, 8'h00);
    read_reg(8'h0B, rd);
    check_eq("t6_ver", rd, 8'h73);
    check_eq("strobe_width", strobe_max, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
